tm1638_responder: RTL and testbench

Synthesizable model of the TM1638 LED/key driver chip: the responder end of the serial link that `tm1638_board_controller` drives. It sits on the board-side pins in self-test and simulation builds. It decodes the STB/CLK/DIO command stream into 16 bytes of display RAM and a display-control register. On read commands it returns scanned key data on DIO, so the controller can be exercised without a physical board.

---
 rtl/tm1638_responder.sv | 173 +++++++++++++++++
 tb/tb_tm1638_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/tm1638_responder.sv
// Board-side model of a TM1638 LED/key driver: decodes the STB/CLK/DIO command
// stream into display RAM and display control, and serves key scan data on reads.
module tm1638_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         sio_clk,
  input  logic         sio_stb,
  input  logic         sio_data_in,
  output logic         sio_data_out,
  output logic         sio_data_out_en,
  input  logic [7:0]   keys,
  output logic [127:0] ram,
  output logic         display_on,
  output logic [2:0]   brightness,
  output logic         protocol_error
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WDATA,
    RDATA,
    IGNORE
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] clk_sync, stb_sync, data_sync;
  logic        clk_hist, stb_hist;
  logic        clk_s, stb_s, data_s;
  logic        clk_rise, clk_fall, stb_fall;

  logic [6:0]  shift;
  logic [2:0]  bit_cnt;
  logic [3:0]  addr;
  logic        fixed_mode;
  logic [31:0] key_snap;
  logic [31:0] key_word;
  logic [4:0]  rd_idx;

  logic [7:0]  rx_byte;
  logic        rx_state;
  logic        byte_done;
  logic        abort_err;
  logic        cmd_err;

  // Synchronizers carry no reset so that a strobe held low across reset
  // never appears as a fresh falling edge afterwards.
  always_ff @(posedge clock) begin
    clk_sync  <= {clk_sync[SYNC_STAGES-2:0], sio_clk};
    stb_sync  <= {stb_sync[SYNC_STAGES-2:0], sio_stb};
    data_sync <= {data_sync[SYNC_STAGES-2:0], sio_data_in};
    clk_hist  <= clk_sync[SYNC_STAGES-1];
    stb_hist  <= stb_sync[SYNC_STAGES-1];
  end

  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign stb_s    = stb_sync[SYNC_STAGES-1];
  assign data_s   = data_sync[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_hist & ~stb_s;
  assign clk_fall = ~clk_s & clk_hist & ~stb_s;
  assign stb_fall = ~stb_s & stb_hist;

  always_comb begin
    key_word = '0;
    for (int i = 0; i < 4; i++) begin
      key_word[8*i]   = keys[i];
      key_word[8*i+4] = keys[i+4];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    rx_byte    = {data_s, shift};
    rx_state   = (state == CMD) || (state == WDATA) || (state == IGNORE);
    byte_done  = rx_state && clk_rise && (bit_cnt == 3'd7);
    abort_err  = stb_s && rx_state && (bit_cnt != 3'd0);
    cmd_err    = (state == CMD) && byte_done && (rx_byte[7:6] == 2'b00);
    unique case (state)
      IDLE:  if (stb_fall) state_next = CMD;
      CMD: begin
        if (stb_s) state_next = IDLE;
        else if (byte_done) begin
          unique case (rx_byte[7:6])
            2'b01:   state_next = rx_byte[1] ? RDATA : IGNORE;
            2'b11:   state_next = WDATA;
            default: state_next = IGNORE;
          endcase
        end
      end
      WDATA:  if (stb_s) state_next = IDLE;
      RDATA: begin
        if (stb_s) state_next = IDLE;
        else if (clk_rise && rd_idx == 5'd31) state_next = IGNORE;
      end
      IGNORE: if (stb_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ram             <= '0;
      display_on      <= 1'b0;
      brightness      <= 3'd0;
      sio_data_out    <= 1'b1;
      sio_data_out_en <= 1'b0;
      protocol_error  <= 1'b0;
      shift           <= '0;
      bit_cnt         <= 3'd0;
      addr            <= 4'd0;
      fixed_mode      <= 1'b0;
      key_snap        <= '0;
      rd_idx          <= 5'd0;
    end else begin
      protocol_error <= abort_err | cmd_err;
      if (stb_s || state == IDLE) begin
        bit_cnt         <= 3'd0;
        rd_idx          <= 5'd0;
        sio_data_out_en <= 1'b0;
        sio_data_out    <= 1'b1;
      end else begin
        if (clk_rise && rx_state) begin
          shift   <= rx_byte[7:1];
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (byte_done && state == CMD) begin
          unique case (rx_byte[7:6])
            2'b01: begin
              fixed_mode <= rx_byte[2];
              if (rx_byte[1]) begin
                key_snap        <= key_word;
                sio_data_out    <= keys[0];
                sio_data_out_en <= 1'b1;
                rd_idx          <= 5'd0;
              end
            end
            2'b10: begin
              display_on <= rx_byte[3];
              brightness <= rx_byte[2:0];
            end
            2'b11:   addr <= rx_byte[3:0];
            default: ;
          endcase
        end
        if (byte_done && state == WDATA) begin
          ram[{addr, 3'b000} +: 8] <= rx_byte;
          if (!fixed_mode) addr <= addr + 4'd1;
        end
        // rd_idx counts bits already sampled; a fall re-presents the next unsampled bit
        if (state == RDATA) begin
          if (clk_rise) begin
            rd_idx <= rd_idx + 5'd1;
            if (rd_idx == 5'd31) begin
              sio_data_out_en <= 1'b0;
              sio_data_out    <= 1'b1;
            end
          end else if (clk_fall) begin
            sio_data_out <= key_snap[rd_idx];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tm1638_responder.sv
// Directed bench for tm1638_responder: drives the serial link like the board
// controller and checks RAM, control registers, read data and error pulses.
module tb_tm1638_responder;

  localparam int HOLD = 8;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         sio_clk = 1'b1;
  logic         sio_stb = 1'b1;
  logic         sio_data_in = 1'b1;
  logic [7:0]   keys = 8'h00;
  logic         sio_data_out;
  logic         sio_data_out_en;
  logic [127:0] ram;
  logic         display_on;
  logic [2:0]   brightness;
  logic         protocol_error;

  int compare_cnt = 0;
  int fail_cnt = 0;
  int err_pulses = 0;

  logic [127:0] exp_ram = '0;
  logic [7:0]   exp_q[$];
  logic [31:0]  rd_bits;
  logic         en_ok;

  tm1638_responder #(.SYNC_STAGES(2)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .sio_clk(sio_clk),
    .sio_stb(sio_stb),
    .sio_data_in(sio_data_in),
    .sio_data_out(sio_data_out),
    .sio_data_out_en(sio_data_out_en),
    .keys(keys),
    .ram(ram),
    .display_on(display_on),
    .brightness(brightness),
    .protocol_error(protocol_error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (reset_n && protocol_error) err_pulses++;
  end

  task automatic waitClocks(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    compare_cnt++;
    assert (observed === expected) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic sendBits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      sio_clk = 1'b0;
      sio_data_in = b[i];
      waitClocks(HOLD);
      sio_clk = 1'b1;
      waitClocks(HOLD);
    end
  endtask

  // Samples DIO just before each rise, while also confirming the driver is enabled
  task automatic readBits(input int n, output logic [31:0] v, output logic ok);
    v = '0;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      sio_clk = 1'b0;
      waitClocks(HOLD);
      v[i] = sio_data_out;
      if (sio_data_out_en !== 1'b1) ok = 1'b0;
      sio_clk = 1'b1;
      waitClocks(HOLD);
    end
  endtask

  task automatic applyStimulus(input int n, input logic [7:0] b0,
                               input logic [7:0] b1, input logic [7:0] b2);
    sio_stb = 1'b0;
    waitClocks(HOLD);
    if (n > 0) sendBits(b0, 8);
    if (n > 1) sendBits(b1, 8);
    if (n > 2) sendBits(b2, 8);
    sio_stb = 1'b1;
    waitClocks(HOLD);
  endtask

  task automatic popCompare(input string tag, input logic [7:0] observed);
    logic [7:0] expected;
    if (exp_q.size() == 0) begin
      compare_cnt++;
      fail_cnt++;
      $error("[TB] FAIL %s: observed=%0h expected=<empty scoreboard>", tag, observed);
    end else begin
      expected = exp_q.pop_front();
      checkOutput(tag, observed, expected);
    end
  endtask

  initial begin
    $display("[TB] starting tm1638_responder bench");
    waitClocks(5);
    reset_n = 1'b1;
    waitClocks(4);

    checkOutput("reset_ram", ram, 128'd0);
    checkOutput("reset_display_on", display_on, 1'b0);
    checkOutput("reset_brightness", brightness, 3'd0);
    checkOutput("reset_dout", sio_data_out, 1'b1);
    checkOutput("reset_dout_en", sio_data_out_en, 1'b0);
    checkOutput("reset_perr", protocol_error, 1'b0);

    // Auto-increment write of bytes 0 and 1
    applyStimulus(1, 8'h40, 8'h00, 8'h00);
    applyStimulus(3, 8'hC0, 8'h3F, 8'h01);
    exp_ram[7:0]  = 8'h3F;
    exp_ram[15:8] = 8'h01;
    checkOutput("write_auto", ram, exp_ram);
    checkOutput("write_no_perr", err_pulses, 0);

    applyStimulus(1, 8'h8F, 8'h00, 8'h00);
    checkOutput("disp_on_8f", display_on, 1'b1);
    checkOutput("bright_8f", brightness, 3'd7);
    applyStimulus(1, 8'h80, 8'h00, 8'h00);
    checkOutput("disp_on_80", display_on, 1'b0);
    checkOutput("bright_80", brightness, 3'd0);

    // Key read: 0x21 -> bytes 01 10 00 00
    keys = 8'h21;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    sio_stb = 1'b0;
    waitClocks(HOLD);
    sendBits(8'h42, 8);
    checkOutput("read_en_start", sio_data_out_en, 1'b1);
    readBits(32, rd_bits, en_ok);
    for (int i = 0; i < 4; i++) popCompare($sformatf("read_byte%0d", i), rd_bits[8*i +: 8]);
    checkOutput("read_en_window", en_ok, 1'b1);
    checkOutput("read_en_after", sio_data_out_en, 1'b0);
    checkOutput("read_dout_after", sio_data_out, 1'b1);
    sio_stb = 1'b1;
    waitClocks(HOLD);
    checkOutput("read_ram_unchanged", ram, exp_ram);
    checkOutput("read_no_perr", err_pulses, 0);

    // Address wrap 15 -> 0, then fixed-address write
    applyStimulus(1, 8'h40, 8'h00, 8'h00);
    applyStimulus(3, 8'hCF, 8'hAA, 8'h55);
    exp_ram[127:120] = 8'hAA;
    exp_ram[7:0]     = 8'h55;
    checkOutput("write_wrap", ram, exp_ram);
    applyStimulus(1, 8'h44, 8'h00, 8'h00);
    applyStimulus(3, 8'hC2, 8'h12, 8'h34);
    exp_ram[23:16] = 8'h34;
    checkOutput("write_fixed", ram, exp_ram);

    // Partial byte aborted by STB
    sio_stb = 1'b0;
    waitClocks(HOLD);
    sendBits(8'hC0, 8);
    sendBits(8'hFF, 5);
    sio_stb = 1'b1;
    waitClocks(HOLD);
    checkOutput("abort_ram", ram, exp_ram);
    checkOutput("abort_perr", err_pulses, 1);
    applyStimulus(1, 8'h40, 8'h00, 8'h00);
    applyStimulus(3, 8'hC4, 8'h66, 8'h77);
    exp_ram[39:32] = 8'h66;
    exp_ram[47:40] = 8'h77;
    checkOutput("after_abort_write", ram, exp_ram);
    checkOutput("after_abort_perr", err_pulses, 1);

    applyStimulus(1, 8'h00, 8'h00, 8'h00);
    checkOutput("bad_cmd_perr", err_pulses, 2);
    checkOutput("bad_cmd_ram", ram, exp_ram);

    // Reset in the middle of a read
    applyStimulus(1, 8'h8B, 8'h00, 8'h00);
    checkOutput("disp_on_8b", display_on, 1'b1);
    checkOutput("bright_8b", brightness, 3'd3);
    keys = 8'h5A;
    exp_q.push_back(8'h10);
    sio_stb = 1'b0;
    waitClocks(HOLD);
    sendBits(8'h42, 8);
    readBits(8, rd_bits, en_ok);
    popCompare("mid_read_byte0", rd_bits[7:0]);
    readBits(2, rd_bits, en_ok);
    checkOutput("mid_read_en", en_ok, 1'b1);
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    waitClocks(2);
    exp_ram = '0;
    checkOutput("rst_dout_en", sio_data_out_en, 1'b0);
    checkOutput("rst_dout", sio_data_out, 1'b1);
    checkOutput("rst_ram", ram, exp_ram);
    checkOutput("rst_display_on", display_on, 1'b0);
    checkOutput("rst_brightness", brightness, 3'd0);
    checkOutput("rst_perr", protocol_error, 1'b0);

    // Clocks with STB still low after reset must not start a transaction
    sendBits(8'hC0, 8);
    sendBits(8'h99, 8);
    sio_stb = 1'b1;
    waitClocks(HOLD);
    checkOutput("no_stale_txn", ram, exp_ram);

    // Mode is back to auto-increment after reset
    applyStimulus(3, 8'hC0, 8'h3C, 8'h5D);
    exp_ram[7:0]  = 8'h3C;
    exp_ram[15:8] = 8'h5D;
    checkOutput("post_reset_write", ram, exp_ram);
    checkOutput("post_reset_perr", err_pulses, 2);
    checkOutput("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, fail_cnt);
    $finish;
  end

endmodule
